id_ex_alu_decoder: RTL and testbench
====================================

ID_EX_ALU_DECODER -- requirements
Module: id_ex_alu_decoder

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, datapath and immediate width.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset, using these ports in this order:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
REQ-003 The block SHALL have these ports:
- id_valid  in  1  instruction in ID is valid
- instr  in  32  raw instruction word
- stall  in  1  hold ID/EX contents
- flush  in  1  insert bubble into EX
- ex_valid  out  1  EX slot holds a real instruction
- alu_ctrl  out  4  ALU operation code
- alu_src_imm  out  1  1 = ALU operand b is ex_imm, 0 = rs2 data
- ex_imm  out  XLEN  sign-extended immediate
- reg_write  out  1  writeback enable
- mem_read  out  1  load
- mem_write  out  1  store
- branch  out  1  beq
- illegal  out  1  unsupported encoding

Function
REQ-004 All outputs SHALL be registered (ID/EX pipeline register), with 1-cycle latency from instr/id_valid to outputs.
REQ-005 alu_ctrl encodings SHALL be: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOP 1111.
REQ-006 Opcode 0110011 (R-type) decode:
- funct3 000 / funct7 0000000 -> ADD
- funct3 000 / funct7 0100000 -> SUB
- funct3 111 -> AND
- funct3 110 -> OR
- funct3 010 -> SLT
- all with funct7 0000000 except SUB
- reg_write=1, alu_src_imm=0.
REQ-007 Opcode 0010011 decode:
- funct3 000 -> ADD
- funct3 111 -> AND
- funct3 110 -> OR
- funct3 010 -> SLT
- reg_write=1, alu_src_imm=1, I-immediate.
REQ-008 Opcode 0000011 with funct3 010 (lw) SHALL decode to ADD, mem_read=1, reg_write=1, alu_src_imm=1, I-immediate.
REQ-009 Opcode 0100011 with funct3 010 (sw) SHALL decode to ADD, mem_write=1, alu_src_imm=1, S-immediate.
REQ-010 Opcode 1100011 with funct3 000 (beq) SHALL decode to SUB, branch=1, alu_src_imm=0, B-immediate.
REQ-011 Immediate formats SHALL be sign-extended to XLEN:
- I = instr[31:20]
- S = {instr[31:25], instr[11:7]}
- B = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
REQ-012 Any other encoding with id_valid=1 SHALL load ex_valid=1, illegal=1, alu_ctrl=1111, ex_imm=0, and all enables 0.
REQ-013 id_valid=0 (not stalled, not flushed) SHALL load a bubble: ex_valid=0, alu_ctrl=1111, ex_imm=0, and all other outputs 0.
REQ-014 stall=1 SHALL hold every output register unchanged.
REQ-015 flush=1 SHALL load a bubble, per REQ-013, regardless of stall.
- Flush has priority over stall.
REQ-016 A bubble or illegal slot SHALL never assert reg_write, mem_read, mem_write or branch.

Reset
REQ-017 While rst_n=0 at a rising edge, the block SHALL load the bubble state, per REQ-013.
- Reset has priority over flush and stall.
REQ-018 Reset asserted mid-stall SHALL discard the held instruction.
- First output after release SHALL reflect instr/id_valid sampled on the first edge with rst_n=1.

Structure
REQ-019 The alu_ctrl encodings (AND/OR/ADD/SUB/SLT/NOP) and opcode constants SHALL live in a shared package consumed by this block and the EX-stage ALU.
REQ-020 Combinational decode SHALL be one sub-module, imm_gen, producing ex_imm input from instr and format.
- The pipeline register and stall/flush logic SHALL stay in the top.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- add x3,x1,x2 (0x002081B3), id_valid=1 -> next cycle: alu_ctrl=0010, reg_write=1, alu_src_imm=0, ex_valid=1.
- addi x1,x0,-1 (0xFFF00093) -> alu_ctrl=0010, alu_src_imm=1, ex_imm=0xFFFFFFFF.
- sw x2,8(x1) (0x0020A423) -> alu_ctrl=0010, mem_write=1, reg_write=0, ex_imm=0x00000008.
- beq x1,x2,-4 (0xFE208EE3) -> alu_ctrl=0110, branch=1, ex_imm=0xFFFFFFFC.
- sub loaded, then stall=1 for 3 cycles with instr changing -> outputs frozen.
  - flush=1 with stall=1 -> bubble next cycle.
  - rst_n=0 -> bubble.
- Illegal word 0xFFFFFFFF -> illegal=1, alu_ctrl=1111, all enables 0.

Source files
------------

// File: rtl/id_ex_alu_decoder_pkg.sv
// Shared ALU operation codes, RV32I opcode constants and ID/EX control bundle.
// Consumed by the ID/EX decoder and the EX-stage ALU.
package id_ex_alu_decoder_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOP = 4'b1111
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B
    } imm_fmt_e;

    typedef struct packed {
        logic    ex_valid;
        alu_op_e alu_ctrl;
        logic    alu_src_imm;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        ex_valid:    1'b0,
        alu_ctrl:    ALU_NOP,
        alu_src_imm: 1'b0,
        reg_write:   1'b0,
        mem_read:    1'b0,
        mem_write:   1'b0,
        branch:      1'b0,
        illegal:     1'b0
    };

    // Shared by register and immediate ALU forms; NOP marks an unsupported funct3.
    function automatic alu_op_e arith_op(input logic [2:0] funct3);
        case (funct3)
            F3_ADD:  return ALU_ADD;
            F3_AND:  return ALU_AND;
            F3_OR:   return ALU_OR;
            F3_SLT:  return ALU_SLT;
            default: return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_alu_decoder_imm_gen.sv
// Combinational instruction decode: control bundle plus sign-extended immediate.
// Zero latency; no flow control (pure function of the instruction word).
module imm_gen
    import id_ex_alu_decoder_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output ctrl_t           ctrl_o,
    output logic [XLEN-1:0] imm_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    imm_fmt_e   fmt;
    alu_op_e    arith;
    logic       unused_rs1;

    assign opcode     = instr_i[6:0];
    assign funct3     = instr_i[14:12];
    assign funct7     = instr_i[31:25];
    assign arith      = arith_op(funct3);
    assign unused_rs1 = ^instr_i[19:15];

    always_comb begin
        // Unless a legal form matches below, the slot is a real but illegal instruction.
        ctrl_o          = CTRL_BUBBLE;
        ctrl_o.ex_valid = 1'b1;
        ctrl_o.illegal  = 1'b1;
        fmt             = IMM_NONE;

        case (opcode)
            OPC_OP: begin
                if (funct3 == F3_ADD && funct7 == F7_ALT) begin
                    ctrl_o.alu_ctrl  = ALU_SUB;
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.illegal   = 1'b0;
                end else if (funct7 == F7_BASE && arith != ALU_NOP) begin
                    ctrl_o.alu_ctrl  = arith;
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.illegal   = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                if (arith != ALU_NOP) begin
                    ctrl_o.alu_ctrl    = arith;
                    ctrl_o.alu_src_imm = 1'b1;
                    ctrl_o.reg_write   = 1'b1;
                    ctrl_o.illegal     = 1'b0;
                    fmt                = IMM_I;
                end
            end
            OPC_LOAD: begin
                if (funct3 == F3_LW) begin
                    ctrl_o.alu_ctrl    = ALU_ADD;
                    ctrl_o.alu_src_imm = 1'b1;
                    ctrl_o.reg_write   = 1'b1;
                    ctrl_o.mem_read    = 1'b1;
                    ctrl_o.illegal     = 1'b0;
                    fmt                = IMM_I;
                end
            end
            OPC_STORE: begin
                if (funct3 == F3_SW) begin
                    ctrl_o.alu_ctrl    = ALU_ADD;
                    ctrl_o.alu_src_imm = 1'b1;
                    ctrl_o.mem_write   = 1'b1;
                    ctrl_o.illegal     = 1'b0;
                    fmt                = IMM_S;
                end
            end
            OPC_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    ctrl_o.alu_ctrl = ALU_SUB;
                    ctrl_o.branch   = 1'b1;
                    ctrl_o.illegal  = 1'b0;
                    fmt             = IMM_B;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        imm_o = '0;
        case (fmt)
            IMM_I: imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_o = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_alu_decoder.sv
// ID/EX pipeline register holding decoded ALU/memory/branch control and immediate.
// 1-cycle latency; stall holds the register, flush (over stall) loads a bubble.
module id_ex_alu_decoder
    import id_ex_alu_decoder_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [31:0]     instr,
    input  logic            stall,
    input  logic            flush,
    output logic            ex_valid,
    output logic [3:0]      alu_ctrl,
    output logic            alu_src_imm,
    output logic [XLEN-1:0] ex_imm,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            illegal
);

    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    ctrl_t           ctrl_d, ctrl_q;
    logic [XLEN-1:0] imm_d, imm_q;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (instr),
        .ctrl_o  (dec_ctrl),
        .imm_o   (dec_imm)
    );

    always_comb begin
        ctrl_d = ctrl_q;
        imm_d  = imm_q;
        if (flush || (!stall && !id_valid)) begin
            ctrl_d = CTRL_BUBBLE;
            imm_d  = '0;
        end else if (!stall) begin
            ctrl_d = dec_ctrl;
            imm_d  = dec_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= CTRL_BUBBLE;
            imm_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            imm_q  <= imm_d;
        end
    end

    assign ex_valid    = ctrl_q.ex_valid;
    assign alu_ctrl    = ctrl_q.alu_ctrl;
    assign alu_src_imm = ctrl_q.alu_src_imm;
    assign ex_imm      = imm_q;
    assign reg_write   = ctrl_q.reg_write;
    assign mem_read    = ctrl_q.mem_read;
    assign mem_write   = ctrl_q.mem_write;
    assign branch      = ctrl_q.branch;
    assign illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_decoder.sv
// Scoreboard bench for id_ex_alu_decoder: stimulus queues expected EX slots,
// a monitor compares the registered outputs one cycle after each applied edge.
module tb_id_ex_alu_decoder;

    typedef struct packed {
        logic        ev;
        logic [3:0]  alu;
        logic        src;
        logic [31:0] imm;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        ill;
    } exp_t;

    localparam exp_t BUB = '{ev:1'b0, alu:4'hF, src:1'b0, imm:32'h0, rw:1'b0,
                             mr:1'b0, mw:1'b0, br:1'b0, ill:1'b0};
    localparam exp_t ILL = '{ev:1'b1, alu:4'hF, src:1'b0, imm:32'h0, rw:1'b0,
                             mr:1'b0, mw:1'b0, br:1'b0, ill:1'b1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid, alu_src_imm, reg_write, mem_read, mem_write, branch, illegal;
    logic [3:0]  alu_ctrl;
    logic [31:0] ex_imm;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    id_ex_alu_decoder #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .instr       (instr),
        .stall       (stall),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .alu_ctrl    (alu_ctrl),
        .alu_src_imm (alu_src_imm),
        .ex_imm      (ex_imm),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .branch      (branch),
        .illegal     (illegal)
    );

    function automatic exp_t ok(input logic [3:0] alu, input logic src, input logic [31:0] imm,
                                input logic rw, input logic mr, input logic mw, input logic br);
        exp_t e;
        e = '{ev:1'b1, alu:alu, src:src, imm:imm, rw:rw, mr:mr, mw:mw, br:br, ill:1'b0};
        return e;
    endfunction

    task automatic step(input string nm, input logic rn, input logic iv, input logic st,
                        input logic fl, input logic [31:0] ins, input exp_t e);
        @(negedge clk);
        rst_n    = rn;
        id_valid = iv;
        stall    = st;
        flush    = fl;
        instr    = ins;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: every edge that had stimulus queued yields one EX slot to check.
    initial begin
        exp_t  e;
        exp_t  got;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = '{ev:ex_valid, alu:alu_ctrl, src:alu_src_imm, imm:ex_imm, rw:reg_write,
                        mr:mem_read, mw:mem_write, br:branch, ill:illegal};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL %s: got v=%b alu=%b src=%b imm=%h rw=%b mr=%b mw=%b br=%b ill=%b, want v=%b alu=%b src=%b imm=%h rw=%b mr=%b mw=%b br=%b ill=%b",
                             nm, got.ev, got.alu, got.src, got.imm, got.rw, got.mr, got.mw, got.br, got.ill,
                             e.ev, e.alu, e.src, e.imm, e.rw, e.mr, e.mw, e.br, e.ill);
                end
            end
        end
    end

    initial begin
        exp_t sub_e;
        sub_e = ok(4'b0110, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        step("reset",      1'b0, 1'b1, 1'b0, 1'b0, 32'h002081B3, BUB);
        step("add",        1'b1, 1'b1, 1'b0, 1'b0, 32'h002081B3, ok(4'b0010, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        step("addi_m1",    1'b1, 1'b1, 1'b0, 1'b0, 32'hFFF00093, ok(4'b0010, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0));
        step("sw",         1'b1, 1'b1, 1'b0, 1'b0, 32'h0020A423, ok(4'b0010, 1'b1, 32'h00000008, 1'b0, 1'b0, 1'b1, 1'b0));
        step("beq_m4",     1'b1, 1'b1, 1'b0, 1'b0, 32'hFE208EE3, ok(4'b0110, 1'b0, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 1'b1));
        step("lw",         1'b1, 1'b1, 1'b0, 1'b0, 32'h0100A283, ok(4'b0010, 1'b1, 32'h00000010, 1'b1, 1'b1, 1'b0, 1'b0));
        step("ori_m16",    1'b1, 1'b1, 1'b0, 1'b0, 32'hFF006093, ok(4'b0001, 1'b1, 32'hFFFFFFF0, 1'b1, 1'b0, 1'b0, 1'b0));
        step("and",        1'b1, 1'b1, 1'b0, 1'b0, 32'h0020F1B3, ok(4'b0000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        step("or",         1'b1, 1'b1, 1'b0, 1'b0, 32'h0020E1B3, ok(4'b0001, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        step("slt",        1'b1, 1'b1, 1'b0, 1'b0, 32'h0020A1B3, ok(4'b0111, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        step("illegal_ff", 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, ILL);
        step("and_f7bad",  1'b1, 1'b1, 1'b0, 1'b0, 32'h4020F1B3, ILL);
        step("no_valid",   1'b1, 1'b0, 1'b0, 1'b0, 32'h002081B3, BUB);
        step("sub",        1'b1, 1'b1, 1'b0, 1'b0, 32'h402081B3, sub_e);
        step("stall1",     1'b1, 1'b1, 1'b1, 1'b0, 32'hFFF00093, sub_e);
        step("stall2",     1'b1, 1'b1, 1'b1, 1'b0, 32'h0020A423, sub_e);
        step("stall3",     1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, sub_e);
        step("flush_stall",1'b1, 1'b1, 1'b1, 1'b1, 32'h002081B3, BUB);
        step("sub2",       1'b1, 1'b1, 1'b0, 1'b0, 32'h402081B3, sub_e);
        step("flush",      1'b1, 1'b1, 1'b0, 1'b1, 32'hFFF00093, BUB);
        step("sub3",       1'b1, 1'b1, 1'b0, 1'b0, 32'h402081B3, sub_e);
        step("rst_stall",  1'b0, 1'b1, 1'b1, 1'b0, 32'h402081B3, BUB);
        step("post_rst",   1'b1, 1'b1, 1'b0, 1'b0, 32'hFFF00093, ok(4'b0010, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0));
        step("tail_bub",   1'b1, 1'b0, 1'b0, 1'b0, 32'h0, BUB);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected slots never observed, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
